dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Multi-cycle data-memory access controller between the CPU memory stage and a synchronous single-port data memory.
- Accepts one load or store per request handshake and issues the memory read and/or write.
- Performs read-modify-write for SB/SH and extracts and extends sub-word load data.
- Reports completion or misalignment back to the CPU; the CPU stalls while req_ready is low.

Parameters:
- MEM_AW, 10, width of word address presented to data memory (mem_addr = addr[MEM_AW+1:2])

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  CPU presents an access this cycle
- req_ready  out  1  controller can accept; high only in IDLE and not in reset
- req_addr  in  32  byte address
- req_access  in  4  access code: LW=0, LH=1, LB=2, LHU=3, LBU=4, SW=5, SH=6, SB=7; 8-15 invalid
- req_wdata  in  32  store data; low byte/half used for SB/SH
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_valid; misaligned or invalid access
- resp_rdata  out  32  extended load data, valid with resp_valid on loads; 0 otherwise
- mem_addr  out  MEM_AW  word address to memory
- mem_re  out  1  read strobe; data appears on mem_rdata next cycle
- mem_we  out  1  write strobe; word written at end of cycle
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  read data, registered inside memory, valid the cycle after mem_re

Behaviour:
- Reset (rst=1 at edge):
  - State becomes IDLE; request registers are cleared.
  - While rst=1, req_ready, resp_valid, resp_err, mem_re and mem_we are forced to 0, combinationally gated, even mid-operation.
  - resp_rdata, mem_wdata and mem_addr read 0.
- Accept: at an edge with req_valid && req_ready, capture addr, access and wdata into the *_q registers. The accept cycle is T.
- States: IDLE, RD, LD_RSP, WR, ERR.
- IDLE→ERR when the captured access is misaligned or invalid:
  - LW/SW with addr[1:0]≠0
  - LH/LHU/SH with addr[0]=1
  - code >7
- IDLE→RD for valid loads and for SH/SB.
- IDLE→WR for valid SW.
- RD: mem_re=1 with mem_addr from addr_q. Next state is LD_RSP for loads, WR for SH/SB.
- LD_RSP: resp_valid=1, resp_rdata = extracted mem_rdata, then IDLE. Load latency: resp at T+2.
- WR: mem_we=1, resp_valid=1, then IDLE.
  - SW: mem_wdata = wdata_q, resp at T+1.
  - SH/SB: mem_wdata = mem_rdata with the addressed byte/half lane replaced by wdata_q[7:0]/[15:0], resp at T+2.
- ERR: resp_valid=1, resp_err=1, resp_rdata=0, no mem_re/mem_we; then IDLE. resp at T+1.
- Load extraction:
  - Byte lane addr_q[1:0], half lane addr_q[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- mem_re and mem_we are never both high.
- mem_addr holds addr_q in every non-IDLE state.
- req_ready is low from T+1 until the state returns to IDLE. A new request can be accepted the cycle after resp_valid, never in the same cycle.
- req_valid/req_addr changes while not ready are ignored; captured values are used throughout.

Decomposition:
- Shared package dmem_pkg holds:
  - access-code constants (LW..SB)
  - state encoding
  - a misalign-check function
- One combinational sub-module, dmem_lane_merge, takes mem word, addr[1:0], access code and store data, and produces the extended load word and the merged store word. The FSM stays in dmem_access_ctrl.

Test Plan:
- Preload word 0x40 (byte addr 0x100) = 0x8899AABB; LB 0x103 accepted at T → mem_re at T+1, resp_valid at T+2, resp_rdata=0xFFFFFF88, resp_err=0.
- LHU 0x102 → resp_rdata=0x00008899 at T+2; LH 0x100 → 0xFFFFAABB.
- SB 0x101, wdata 0x12345677 → mem_re at T+1, mem_we at T+2 with mem_wdata=0x889977BB; a following LW 0x100 returns 0x889977BB.
- SW 0x104, wdata 0xDEADBEEF → mem_we at T+1, mem_addr=0x41, resp_valid at T+1, no mem_re.
- SH 0x101 and LW 0x102 → resp_err=1 at T+1, mem_re=mem_we=0 throughout, memory unchanged; code 0xA at an aligned address → resp_err=1.
- SB 0x100 with rst asserted during the WR cycle → mem_we=0 that cycle, memory word unchanged, req_ready=1 the cycle after rst drops.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller:
// access-code constants, FSM state encoding and the alignment check.
package dmem_pkg;

  localparam logic [3:0] ACC_LW  = 4'd0;
  localparam logic [3:0] ACC_LH  = 4'd1;
  localparam logic [3:0] ACC_LB  = 4'd2;
  localparam logic [3:0] ACC_LHU = 4'd3;
  localparam logic [3:0] ACC_LBU = 4'd4;
  localparam logic [3:0] ACC_SW  = 4'd5;
  localparam logic [3:0] ACC_SH  = 4'd6;
  localparam logic [3:0] ACC_SB  = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_LD_RSP = 3'd2,
    ST_WR     = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  // Loads are codes 0..4; everything from SW upwards is a store or invalid.
  function automatic logic dmem_is_load(input logic [3:0] acc);
    return (acc <= ACC_LBU);
  endfunction

  // True when the access cannot be performed: invalid code, or an address
  // that is not aligned to the access size.
  function automatic logic dmem_misaligned(input logic [1:0] off, input logic [3:0] acc);
    logic bad;
    bad = 1'b0;
    if (acc > ACC_SB) begin
      bad = 1'b1;
    end else if ((acc == ACC_LW) || (acc == ACC_SW)) begin
      bad = (off != 2'b00);
    end else if ((acc == ACC_LH) || (acc == ACC_LHU) || (acc == ACC_SH)) begin
      bad = off[0];
    end
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Byte/half lane logic: extracts and extends load data from a memory word,
// and builds the store word (full word for SW, lane-merged word for SH/SB).
// Purely combinational.
module dmem_lane_merge
  import dmem_pkg::*;
(
  input  logic [31:0] mem_word_i,
  input  logic [1:0]  byte_off_i,
  input  logic [3:0]  access_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_word_o,
  output logic [31:0] store_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte and half-word lanes.
  always_comb begin
    byte_sel = mem_word_i[7:0];
    case (byte_off_i)
      2'd0: byte_sel = mem_word_i[7:0];
      2'd1: byte_sel = mem_word_i[15:8];
      2'd2: byte_sel = mem_word_i[23:16];
      default: byte_sel = mem_word_i[31:24];
    endcase
    half_sel = byte_off_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];
  end

  // Extend the selected lane according to the load type.
  always_comb begin
    load_word_o = mem_word_i;
    case (access_i)
      ACC_LH:  load_word_o = {{16{half_sel[15]}}, half_sel};
      ACC_LHU: load_word_o = {16'h0000, half_sel};
      ACC_LB:  load_word_o = {{24{byte_sel[7]}}, byte_sel};
      ACC_LBU: load_word_o = {24'h000000, byte_sel};
      default: load_word_o = mem_word_i;
    endcase
  end

  // Replace the addressed lane of the old word with the store data.
  always_comb begin
    store_word_o = mem_word_i;
    case (access_i)
      ACC_SW: store_word_o = wdata_i;
      ACC_SH: begin
        if (byte_off_i[1]) store_word_o[31:16] = wdata_i[15:0];
        else               store_word_o[15:0]  = wdata_i[15:0];
      end
      ACC_SB: begin
        case (byte_off_i)
          2'd0: store_word_o[7:0]   = wdata_i[7:0];
          2'd1: store_word_o[15:8]  = wdata_i[7:0];
          2'd2: store_word_o[23:16] = wdata_i[7:0];
          default: store_word_o[31:24] = wdata_i[7:0];
        endcase
      end
      default: store_word_o = mem_word_i;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Multi-cycle load/store controller in front of a single-port synchronous
// data memory. Loads and sub-word stores read first (sub-word stores then
// write back a merged word); SW writes directly; bad accesses answer with an error.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [3:0]        req_access,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q;
  logic [MEM_AW+1:0] addr_q;
  logic [3:0]        access_q;
  logic [31:0]       wdata_q;

  logic [31:0] load_word;
  logic [31:0] store_word;

  // Address bits above the memory window do not select anything.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

  dmem_lane_merge u_lane_merge (
    .mem_word_i  (mem_rdata),
    .byte_off_i  (addr_q[1:0]),
    .access_i    (access_q),
    .wdata_i     (wdata_q),
    .load_word_o (load_word),
    .store_word_o(store_word)
  );

  // Access FSM: capture the request in IDLE and route by access type.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      access_q <= ACC_LW;
      wdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr[MEM_AW+1:0];
            access_q <= req_access;
            wdata_q  <= req_wdata;
            if (dmem_misaligned(req_addr[1:0], req_access)) state_q <= ST_ERR;
            else if (req_access == ACC_SW)                  state_q <= ST_WR;
            else                                            state_q <= ST_RD;
          end
        end
        ST_RD:     state_q <= dmem_is_load(access_q) ? ST_LD_RSP : ST_WR;
        ST_LD_RSP: state_q <= ST_IDLE;
        ST_WR:     state_q <= ST_IDLE;
        ST_ERR:    state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode the current state; reset masks them immediately.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_addr   = '0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    if (!rst) begin
      mem_addr = addr_q[MEM_AW+1:2];
      case (state_q)
        ST_IDLE: req_ready = 1'b1;
        ST_RD:   mem_re = 1'b1;
        ST_LD_RSP: begin
          resp_valid = 1'b1;
          resp_rdata = load_word;
        end
        ST_WR: begin
          mem_we     = 1'b1;
          mem_wdata  = store_word;
          resp_valid = 1'b1;
        end
        ST_ERR: begin
          resp_valid = 1'b1;
          resp_err   = 1'b1;
        end
        default: req_ready = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Testbench for dmem_access_ctrl: directed cases plus random accesses,
// checked against a word-array reference model of memory contents.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_access;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [9:0]  mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] dmem    [0:1023];
  logic [31:0] ref_mem [0:1023];

  dmem_access_ctrl #(.MEM_AW(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_access(req_access),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_err  (resp_err),
    .resp_rdata(resp_rdata),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory attached to the controller.
  always @(posedge clk) begin
    if (mem_we) dmem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= dmem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected load result computed with plain shifts and offsets.
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [3:0] code);
    logic [31:0] w, b, h;
    w = ref_mem[a[11:2]];
    b = (w >> (a[1:0] * 8)) & 32'hFF;
    h = (w >> (a[1] * 16)) & 32'hFFFF;
    case (code)
      4'd0: return w;
      4'd1: return (h >= 32'h8000) ? h - 32'h10000 : h;
      4'd2: return (b >= 32'h80) ? b - 32'h100 : b;
      4'd3: return h;
      4'd4: return b;
      default: return 32'h0;
    endcase
  endfunction

  // Memory word expected after a store completes.
  function automatic logic [31:0] ref_store(input logic [31:0] a, input logic [3:0] code,
                                            input logic [31:0] wd);
    logic [31:0] w, m;
    w = ref_mem[a[11:2]];
    if (code == 4'd5) return wd;
    if (code == 4'd6) begin
      m = 32'hFFFF << (a[1] * 16);
      return (w & ~m) | ((wd & 32'hFFFF) << (a[1] * 16));
    end
    m = 32'hFF << (a[1:0] * 8);
    return (w & ~m) | ((wd & 32'hFF) << (a[1:0] * 8));
  endfunction

  function automatic logic ref_bad(input logic [31:0] a, input logic [3:0] code);
    if (code > 4'd7) return 1'b1;
    if ((code == 4'd0 || code == 4'd5) && a[1:0] != 2'd0) return 1'b1;
    if ((code == 4'd1 || code == 4'd3 || code == 4'd6) && a[0]) return 1'b1;
    return 1'b0;
  endfunction

  // One complete access: issue, watch each cycle until the response, update the model.
  task automatic run_access(input logic [31:0] a, input logic [3:0] code, input logic [31:0] wd);
    logic bad, is_st, is_sw;
    int lat;
    logic [31:0] exp_rd, exp_wr;
    bad    = ref_bad(a, code);
    is_st  = (code >= 4'd5) && !bad;
    is_sw  = (code == 4'd5) && !bad;
    lat    = (bad || is_sw) ? 1 : 2;
    exp_rd = (!bad && code <= 4'd4) ? ref_load(a, code) : 32'h0;
    exp_wr = is_st ? ref_store(a, code, wd) : 32'h0;
    @(negedge clk);
    check("ready_before", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_addr = a; req_access = code; req_wdata = wd;
    @(posedge clk);
    #1;
    // Busy-time request changes must be ignored.
    req_addr = $urandom; req_access = 4'($urandom); req_wdata = $urandom;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check("ready_busy", {31'd0, req_ready}, 32'd0);
      check("mem_re", {31'd0, mem_re}, {31'd0, (!bad && !is_sw && k == 1)});
      check("mem_we", {31'd0, mem_we}, {31'd0, (is_st && k == lat)});
      check("resp_valid", {31'd0, resp_valid}, {31'd0, (k == lat)});
      if (!bad) check("mem_addr", {22'd0, mem_addr}, {22'd0, a[11:2]});
      if (is_st && k == lat) check("mem_wdata", mem_wdata, exp_wr);
      if (k == lat) begin
        check("resp_err", {31'd0, resp_err}, {31'd0, bad});
        check("resp_rdata", resp_rdata, exp_rd);
        req_valid = 1'b0;
      end
    end
    if (is_st) ref_mem[a[11:2]] = exp_wr;
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  c;
    for (int i = 0; i < 1024; i++) begin
      dmem[i] = $urandom;
      ref_mem[i] = dmem[i];
    end
    dmem[10'h40] = 32'h8899AABB;
    ref_mem[10'h40] = 32'h8899AABB;
    mem_rdata = 32'h0;

    // Reset: outputs gated even with a request present.
    rst = 1'b1; req_valid = 1'b1; req_addr = 32'h104; req_access = 4'd5; req_wdata = 32'h1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_mem_re", {31'd0, mem_re}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    req_valid = 1'b0;
    rst = 1'b0;

    // Directed loads on the preloaded word.
    run_access(32'h103, 4'd2, 32'h0);          // LB  -> FFFFFF88
    check("lb_value", resp_rdata, 32'hFFFFFF88);
    run_access(32'h102, 4'd3, 32'h0);          // LHU -> 00008899
    run_access(32'h100, 4'd1, 32'h0);          // LH  -> FFFFAABB
    // Sub-word store then word read-back.
    run_access(32'h101, 4'd7, 32'h12345677);   // SB
    run_access(32'h100, 4'd0, 32'h0);          // LW  -> 889977BB
    check("sb_readback", resp_rdata, 32'h889977BB);
    // Direct word store.
    run_access(32'h104, 4'd5, 32'hDEADBEEF);   // SW  -> word 0x41
    run_access(32'h104, 4'd0, 32'h0);
    // Error cases leave memory untouched.
    run_access(32'h101, 4'd6, 32'hCAFEF00D);   // SH misaligned
    run_access(32'h102, 4'd0, 32'h0);          // LW misaligned
    run_access(32'h100, 4'hA, 32'h0);          // invalid code
    run_access(32'h100, 4'd0, 32'h0);
    check("err_mem_intact", dmem[10'h40], 32'h889977BB);

    // Reset asserted during the write-back cycle of an SB.
    @(negedge clk);
    check("ready_pre_rstwr", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_addr = 32'h100; req_access = 4'd7; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rstwr_mem_re", {31'd0, mem_re}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rstwr_mem_we", {31'd0, mem_we}, 32'd0);
    check("rstwr_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rstwr_ready", {31'd0, req_ready}, 32'd0);
    check("rstwr_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstwr_ready_after", {31'd0, req_ready}, 32'd1);
    check("rstwr_mem_intact", dmem[10'h40], 32'h889977BB);
    run_access(32'h100, 4'd0, 32'h0);

    // Random accesses over a small window so stores and loads interact.
    for (int n = 0; n < 80; n++) begin
      a = {20'd0, 10'($urandom_range(32'h40, 32'h47)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 4) == 0) c = 4'($urandom_range(8, 15));
      else                           c = 4'($urandom_range(0, 7));
      run_access(a, c, $urandom);
    end
    for (int i = 32'h40; i < 32'h48; i++) check("final_mem", dmem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
